// File: rtl/multi_line_buffer_if.sv
// multi_line_buffer_if: pixel stream in, tap column out.
// master drives pixels/ready_i; slave is the buffer.
interface multi_line_buffer_if #(
  parameter int Width     = 8,
  parameter int MaxDelay  = 640,
  parameter int BufferCnt = 2
);
  localparam int LenWidth = $clog2(MaxDelay + 1);

  logic [LenWidth-1:0]             delay_i;
  logic                            sof_i;
  logic [Width-1:0]                data_i;
  logic                            valid_i;
  logic                            ready_o;
  logic [BufferCnt:0][Width-1:0]   data_o;
  logic                            valid_o;
  logic                            ready_i;
  logic                            primed_o;

  modport master (
    output delay_i, sof_i, data_i,
    output valid_i, ready_i,
    input  ready_o, data_o,
    input  valid_o, primed_o
  );

  modport slave (
    input  delay_i, sof_i, data_i,
    input  valid_i, ready_i,
    output ready_o, data_o,
    output valid_o, primed_o
  );
endinterface

// File: rtl/multi_line_buffer.sv
// multi_line_buffer: one vertical column of a
// (BufferCnt+1)-row window per accepted pixel.
// Ports: clk_i, rst_i (sync, active high),
//   bus (slave): delay_i/sof_i/data_i/valid_i
//   -> ready_o; data_o/valid_o/primed_o
//   <- ready_i. data_o[k] is k*D pixels older.
module multi_line_buffer #(
  parameter int Width     = 8,
  parameter int MaxDelay  = 640,
  parameter int BufferCnt = 2,
  parameter int FillMode  = 0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  multi_line_buffer_if.slave  bus
);
  localparam int AddrWidth = $clog2(MaxDelay);
  localparam int LenWidth  = $clog2(MaxDelay + 1);
  localparam int CntWidth  =
    $clog2(BufferCnt * MaxDelay + 1);

  typedef logic [Width-1:0]     pix_t;
  typedef pix_t [BufferCnt-1:0] word_t;
  typedef pix_t [BufferCnt:0]   taps_t;
  typedef logic [CntWidth-1:0]  cnt_t;
  typedef cnt_t [BufferCnt:1]   thr_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [LenWidth-1:0]  len_t;

  addr_t ptr_q, ptr_d;
  cnt_t  n_q, n_d;
  len_t  delay_q, delay_d;
  thr_t  thr_q, thr_d;
  taps_t data_q, data_d;
  logic  valid_q, valid_d;
  logic  primed_q, primed_d;

  // RAM word slot j holds the pixel (j+1)*D
  // older than the pixel about to use it.
  word_t ram [MaxDelay];
  word_t rd_q;
  logic  fwd_q;
  word_t fwd_word_q;

  logic  rdy, in_fire, sof_fire;
  len_t  dly_clamp, dly_eff;
  addr_t wr_addr, rd_addr, ptr_step;
  cnt_t  n_cur;
  logic  primed_cur, n_sat;
  word_t rd_word, wr_word;
  taps_t taps;

  assign rdy      = ~valid_q | bus.ready_i;
  assign in_fire  = bus.valid_i & rdy;
  assign sof_fire = in_fire & bus.sof_i;

  always_comb begin
    dly_clamp = bus.delay_i;
    if (bus.delay_i == '0)
      dly_clamp = len_t'(1);
    else if (bus.delay_i > len_t'(MaxDelay))
      dly_clamp = len_t'(MaxDelay);
  end

  // A frame start takes effect on its own pixel.
  assign dly_eff = sof_fire ? dly_clamp : delay_q;
  assign wr_addr = sof_fire ? '0 : ptr_q;
  assign n_cur   = sof_fire ? '0 : n_q;

  always_comb begin
    ptr_step = wr_addr + addr_t'(1);
    if (len_t'(wr_addr) == dly_eff - len_t'(1))
      ptr_step = '0;
  end

  // D=1 reads the address being written:
  // bypass the RAM with the word just written.
  assign rd_word = fwd_q ? fwd_word_q : rd_q;

  always_comb begin
    wr_word    = '0;
    wr_word[0] = bus.data_i;
    for (int j = 1; j < BufferCnt; j++)
      wr_word[j] = rd_word[j-1];
  end

  // Thresholds were fixed at latch time; an
  // unreached tap reads zero, never stale RAM.
  always_comb begin
    taps    = '0;
    taps[0] = bus.data_i;
    for (int k = 1; k <= BufferCnt; k++)
      if (n_cur >= thr_q[k])
        taps[k] = rd_word[k-1];
  end

  assign primed_cur = n_cur >= thr_q[BufferCnt];
  assign n_sat      = n_q >= thr_q[BufferCnt];

  always_comb begin
    ptr_d    = ptr_q;
    n_d      = n_q;
    delay_d  = delay_q;
    thr_d    = thr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    primed_d = primed_q;
    if (in_fire) begin
      ptr_d    = ptr_step;
      delay_d  = dly_eff;
      data_d   = taps;
      valid_d  = (FillMode == 0) || primed_cur;
      primed_d = primed_cur;
      if (sof_fire) begin
        n_d = cnt_t'(1);
        for (int k = 1; k <= BufferCnt; k++)
          thr_d[k] = cnt_t'(k * int'(dly_clamp));
      end else if (!n_sat) begin
        n_d = n_q + cnt_t'(1);
      end
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Prefetch the word the next pixel will need.
  assign rd_addr = rst_i ? '0 : ptr_d;

  always_ff @(posedge clk_i) begin
    if (in_fire)
      ram[wr_addr] <= wr_word;
    rd_q       <= ram[rd_addr];
    fwd_q      <= in_fire & (wr_addr == rd_addr);
    fwd_word_q <= wr_word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      n_q      <= '0;
      delay_q  <= len_t'(MaxDelay);
      data_q   <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
      for (int k = 1; k <= BufferCnt; k++)
        thr_q[k] <= cnt_t'(k * MaxDelay);
    end else begin
      ptr_q    <= ptr_d;
      n_q      <= n_d;
      delay_q  <= delay_d;
      thr_q    <= thr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
    end
  end

  assign bus.ready_o  = rdy;
  assign bus.data_o   = data_q;
  assign bus.valid_o  = valid_q;
  assign bus.primed_o = primed_q;
endmodule

// File: tb/tb_multi_line_buffer.sv
// tb_multi_line_buffer: directed checks of the
// line buffer, FillMode 0 and 1 side by side.
module tb_multi_line_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vin = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] dly = '0;
  logic       rdy = 1'b1;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  multi_line_buffer_if #(
    .Width(8), .MaxDelay(8), .BufferCnt(2)
  ) if0 ();
  multi_line_buffer_if #(
    .Width(8), .MaxDelay(8), .BufferCnt(2)
  ) if1 ();

  assign if0.valid_i = vin;
  assign if0.sof_i   = sof;
  assign if0.data_i  = din;
  assign if0.delay_i = dly;
  assign if0.ready_i = rdy;
  assign if1.valid_i = vin;
  assign if1.sof_i   = sof;
  assign if1.data_i  = din;
  assign if1.delay_i = dly;
  assign if1.ready_i = rdy;

  multi_line_buffer #(
    .Width(8), .MaxDelay(8),
    .BufferCnt(2), .FillMode(0)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0)
  );

  multi_line_buffer #(
    .Width(8), .MaxDelay(8),
    .BufferCnt(2), .FillMode(1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1)
  );

  function automatic logic [23:0] beat(
    input int t0, input int t1, input int t2
  );
    return {8'(t2), 8'(t1), 8'(t0)};
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic chk0(
    input string tag, input logic [23:0] d,
    input logic v, input logic p
  );
    chk({tag, "_d"}, 32'(if0.data_o), 32'(d));
    chk({tag, "_v"}, 32'(if0.valid_o), 32'(v));
    chk({tag, "_p"}, 32'(if0.primed_o), 32'(p));
  endtask

  // One pixel, fired on the next edge;
  // outputs sampled 1 time unit later.
  task automatic step(
    input int pix, input logic s, input int d
  );
    vin = 1'b1;
    din = 8'(pix);
    sof = s;
    dly = 4'(d);
    @(posedge clk);
    #1;
    vin = 1'b0;
    sof = 1'b0;
  endtask

  initial begin
    int t1, t2;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk0("rst", '0, 1'b0, 1'b0);
    chk("rst_v1", 32'(if1.valid_o), 0);
    chk("rst_rdy", 32'(if0.ready_o), 1);

    // stream 0..16, D=4
    for (int i = 0; i <= 16; i++) begin
      step(i, i == 0, 4);
      t1 = (i >= 4) ? i - 4 : 0;
      t2 = (i >= 8) ? i - 8 : 0;
      chk0($sformatf("s%0d", i),
           beat(i, t1, t2), 1'b1, i >= 8);
      chk($sformatf("f%0d_v", i),
          32'(if1.valid_o), 32'(i >= 8));
      if (i >= 8) begin
        chk($sformatf("f%0d_d", i),
            32'(if1.data_o), 32'(beat(i, t1, t2)));
        chk($sformatf("f%0d_p", i),
            32'(if1.primed_o), 1);
      end
      if (i == 5)
        chk("p5", 32'(if0.data_o), 32'h00_01_05);
      if (i == 8)
        chk("p8", 32'(if0.data_o), 32'h00_04_08);
      if (i == 15)
        chk("p15", 32'(if0.data_o), 32'h07_0b_0f);
    end

    // backpressure 3 cycles with pixel 17 pending
    rdy = 1'b0;
    vin = 1'b1;
    din = 8'd17;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk0($sformatf("bp%0d", c),
           beat(16, 12, 8), 1'b1, 1'b1);
      chk($sformatf("bp%0d_r", c),
          32'(if0.ready_o), 0);
      chk($sformatf("bp%0d_f", c),
          32'(if1.data_o), 32'(beat(16, 12, 8)));
    end
    rdy = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0;
    chk0("bp_rel", beat(17, 13, 9), 1'b1, 1'b1);
    chk("bp_rel_f", 32'(if1.data_o),
        32'(beat(17, 13, 9)));
    step(18, 1'b0, 4);
    chk0("bp_next", beat(18, 14, 10), 1'b1, 1'b1);

    // mid-frame sof, D=3; later delay_i ignored
    step(100, 1'b1, 3);
    chk0("m100", beat(100, 0, 0), 1'b1, 1'b0);
    chk("m100_f", 32'(if1.valid_o), 0);
    step(101, 1'b0, 7);
    step(102, 1'b0, 7);
    chk0("m102", beat(102, 0, 0), 1'b1, 1'b0);
    step(103, 1'b0, 7);
    chk0("m103", beat(103, 100, 0), 1'b1, 1'b0);
    step(104, 1'b0, 7);
    step(105, 1'b0, 7);
    chk0("m105", beat(105, 102, 0), 1'b1, 1'b0);
    chk("m105_f", 32'(if1.valid_o), 0);
    step(106, 1'b0, 7);
    chk0("m106", beat(106, 103, 100), 1'b1, 1'b1);
    chk("m106_fv", 32'(if1.valid_o), 1);
    chk("m106_fd", 32'(if1.data_o),
        32'(beat(106, 103, 100)));

    // clamp: delay_i=0 acts as D=1
    step(0, 1'b1, 0);
    chk0("c0_0", beat(0, 0, 0), 1'b1, 1'b0);
    step(1, 1'b0, 0);
    chk0("c0_1", beat(1, 0, 0), 1'b1, 1'b0);
    step(2, 1'b0, 0);
    chk0("c0_2", beat(2, 1, 0), 1'b1, 1'b1);
    step(3, 1'b0, 0);
    chk0("c0_3", beat(3, 2, 1), 1'b1, 1'b1);

    // clamp: delay_i=12 acts as D=8
    for (int i = 0; i <= 8; i++)
      step(20 + i, i == 0, 12);
    chk0("c12_8", beat(28, 20, 0), 1'b1, 1'b0);

    // reset at pixel 6 of a D=2 frame
    for (int i = 0; i < 6; i++) begin
      step(40 + i, i == 0, 2);
      if (i == 2)
        chk0("r42", beat(42, 40, 0), 1'b1, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk0("r_rst", '0, 1'b0, 1'b0);
    chk("r_rst_f", 32'(if1.valid_o), 0);
    for (int i = 0; i <= 8; i++) begin
      step(50 + i, 1'b0, 2);
      if (i == 0)
        chk0("r50", beat(50, 0, 0), 1'b1, 1'b0);
      if (i == 2)
        chk0("r52", beat(52, 0, 0), 1'b1, 1'b0);
    end
    chk0("r58", beat(58, 50, 0), 1'b1, 1'b0);

    // drain: output clears with no new input
    @(posedge clk);
    #1;
    chk("drain_v", 32'(if0.valid_o), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
